// File: rtl/i2s_sample_arbiter.sv
// Frame-synchronous arbiter sharing one I2S transmitter among several sources.
// One grant per frame at count == FRAME_LEN-2; sample reaches sound_in a cycle before capture.
module i2s_sample_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int WIDTH     = 12,
    parameter int FRAME_LEN = 26
) (
    input  logic                     s_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     rr_mode,
    input  logic [WIDTH-1:0]         silence,
    input  logic [NUM_SRC-1:0]       req_valid,
    input  logic [NUM_SRC*WIDTH-1:0] req_data,
    output logic [NUM_SRC-1:0]       req_ready,
    output logic [WIDTH-1:0]         sound_in,
    output logic                     frame_start,
    output logic [1:0]               active_src,
    output logic                     underrun
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] GRANT = CW'(FRAME_LEN - 2);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sound_q, sound_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             under_q, under_d;
    logic             frame_q, frame_d;

    logic             grant_cyc;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       sel;
    logic [WIDTH-1:0] src_data [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_data[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the lowest-priority candidate upward so the last hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sel       = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (rr_mode) begin
                sel = 2'((int'(rr_ptr_q) + k) % NUM_SRC);
            end else begin
                sel = 2'(k - 1);
            end
            if (req_valid[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    assign grant_cyc = (count_q == GRANT);

    always_comb begin
        req_ready = '0;
        if (grant_cyc && enable && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        count_d  = (count_q == LAST) ? '0 : count_q + 1'b1;
        frame_d  = (count_d == '0);
        sound_d  = sound_q;
        active_d = active_q;
        rr_ptr_d = rr_ptr_q;
        under_d  = 1'b0;
        if (grant_cyc) begin
            if (enable && win_found) begin
                sound_d  = src_data[win_idx];
                active_d = win_idx;
                rr_ptr_d = win_idx;
            end else begin
                sound_d = silence;
                under_d = enable;
            end
        end
    end

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            sound_q  <= silence;
            active_q <= '0;
            rr_ptr_q <= 2'(NUM_SRC - 1);
            under_q  <= 1'b0;
            frame_q  <= 1'b1;
        end else begin
            count_q  <= count_d;
            sound_q  <= sound_d;
            active_q <= active_d;
            rr_ptr_q <= rr_ptr_d;
            under_q  <= under_d;
            frame_q  <= frame_d;
        end
    end

    assign sound_in    = sound_q;
    assign active_src  = active_q;
    assign underrun    = under_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_i2s_sample_arbiter.sv
// Scoreboard bench for i2s_sample_arbiter: per-frame directed vectors,
// expectations queued by the stimulus and checked by a negedge monitor.
module tb_i2s_sample_arbiter;

    typedef struct {
        logic        en;
        logic        rr;
        logic        en_mid;
        logic [2:0]  vld;
        logic [35:0] data;
        logic [2:0]  rdy;
        logic [11:0] snd;
        logic [1:0]  act;
        logic        und;
    } vec_t;

    logic        s_clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        rr_mode = 1'b0;
    logic [11:0] silence = 12'h800;
    logic [2:0]  req_valid = '0;
    logic [35:0] req_data = '0;
    logic [2:0]  req_ready;
    logic [11:0] sound_in;
    logic        frame_start;
    logic [1:0]  active_src;
    logic        underrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t exp_q[$];
    vec_t cur;

    localparam logic [35:0] ALL = {12'h333, 12'h222, 12'h111};

    i2s_sample_arbiter #(.NUM_SRC(3), .WIDTH(12), .FRAME_LEN(26)) dut (
        .s_clk(s_clk),
        .reset(reset),
        .enable(enable),
        .rr_mode(rr_mode),
        .silence(silence),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .sound_in(sound_in),
        .frame_start(frame_start),
        .active_src(active_src),
        .underrun(underrun)
    );

    always #5 s_clk = ~s_clk;

    // Bench's own frame counter, aligned with the transmitter.
    always @(posedge s_clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= (cyc == 25) ? 0 : cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge s_clk) begin
        if (reset) begin
            chk("frame_start", 32'(frame_start), 32'(cyc == 0));
            if (cyc == 24) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                    chk("req_ready", 32'(req_ready), 32'(cur.rdy));
                end
            end else begin
                chk("ready_idle", 32'(req_ready), 32'd0);
            end
            if (cyc == 25) begin
                chk("sound_in", 32'(sound_in), 32'(cur.snd));
                chk("active_src", 32'(active_src), 32'(cur.act));
                chk("underrun", 32'(underrun), 32'(cur.und));
            end else begin
                chk("underrun_idle", 32'(underrun), 32'd0);
            end
        end
    end

    function automatic vec_t mk(input logic en, input logic rr,
                                input logic en_mid, input logic [2:0] vld,
                                input logic [35:0] data, input logic [2:0] rdy,
                                input logic [11:0] snd, input logic [1:0] act,
                                input logic und);
        vec_t v;
        v.en = en; v.rr = rr; v.en_mid = en_mid; v.vld = vld;
        v.data = data; v.rdy = rdy; v.snd = snd; v.act = act; v.und = und;
        return v;
    endfunction

    // Called with cyc == 0; returns with cyc == 0 of the next frame.
    task automatic run_frame(input vec_t v);
        enable    = v.en_mid ? 1'b0 : v.en;
        rr_mode   = v.rr;
        req_valid = v.vld;
        req_data  = v.data;
        exp_q.push_back(v);
        if (v.en_mid) begin
            repeat (10) @(posedge s_clk);
            #1 enable = 1'b1;
            repeat (16) @(posedge s_clk);
        end else begin
            repeat (26) @(posedge s_clk);
        end
        #1;
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    initial begin
        // source 1 alone
        tbl_a.push_back(mk(1, 0, 0, 3'b010, {12'h000, 12'hA5C, 12'h000},
                           3'b010, 12'hA5C, 2'd1, 0));
        // fixed priority, all valid
        repeat (3)
            tbl_a.push_back(mk(1, 0, 0, 3'b111, ALL, 3'b001, 12'h111, 2'd0, 0));
        // round robin from rr_ptr = 0
        tbl_a.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b010, 12'h222, 2'd1, 0));
        tbl_a.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b100, 12'h333, 2'd2, 0));
        tbl_a.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b001, 12'h111, 2'd0, 0));
        tbl_a.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b010, 12'h222, 2'd1, 0));
        // no valid source: underrun
        repeat (2)
            tbl_a.push_back(mk(1, 1, 0, 3'b000, ALL, 3'b000, 12'h800, 2'd1, 1));
        // disabled with source 2 valid
        tbl_a.push_back(mk(0, 1, 0, 3'b100, ALL, 3'b000, 12'h800, 2'd1, 0));
        // re-enabled mid-frame
        tbl_a.push_back(mk(1, 1, 1, 3'b100, ALL, 3'b100, 12'h333, 2'd2, 0));
        // round robin from reset
        tbl_b.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b001, 12'h111, 2'd0, 0));
        tbl_b.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b010, 12'h222, 2'd1, 0));
        tbl_b.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b100, 12'h333, 2'd2, 0));
        tbl_b.push_back(mk(1, 1, 0, 3'b111, ALL, 3'b001, 12'h111, 2'd0, 0));

        #12;
        chk("rst_sound", 32'(sound_in), 32'h800);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd1);
        chk("rst_active", 32'(active_src), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        @(negedge s_clk);
        #1 reset = 1'b1;
        foreach (tbl_a[i]) run_frame(tbl_a[i]);

        // Reset pulsed during the grant cycle
        repeat (24) @(posedge s_clk);
        #1;
        enable = 1'b1; rr_mode = 1'b0;
        req_valid = 3'b001; req_data = ALL;
        #1 chk("pre_rst_ready", 32'(req_ready), 32'b001);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_sound", 32'(sound_in), 32'h800);
        chk("mid_rst_frame_start", 32'(frame_start), 32'd1);
        chk("mid_rst_active", 32'(active_src), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        repeat (3) @(negedge s_clk);
        #1 reset = 1'b1;
        foreach (tbl_b[i]) run_frame(tbl_b[i]);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
